// File: rtl/i2c_nibble_rx.sv
// Passive I2C-style receiver: detects START, shifts DATA_W bits MSB-first on scl rises,
// and presents the word with a one-cycle valid pulse on a clean STOP.
module i2c_nibble_rx #(
  parameter int unsigned DATA_W  = 4,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic              sclk,
  input  logic              rst,
  input  logic              scl,
  input  logic              sda,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              busy,
  output logic              err
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam int unsigned TW   = $clog2(TIMEOUT);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
  localparam logic [TW-1:0]   TLast   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRecv     = 2'd1,
    StWaitStop = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic scl_meta, scl_s, scl_d;
  logic sda_meta, sda_s, sda_d;

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic [TW-1:0]     tcnt_q, tcnt_d;
  logic [DATA_W-1:0] data_d;
  logic              valid_d, busy_d, err_d;

  logic scl_rise, scl_edge, start_c, stop_c, timeout;

  assign scl_rise = scl_s & ~scl_d;
  assign scl_edge = scl_s ^ scl_d;
  assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;
  // Any scl activity or START restarts the inactivity window.
  assign timeout  = (tcnt_q == TLast) & ~scl_edge & ~start_c;

  always_ff @(posedge sclk) begin
    if (rst) begin
      scl_meta  <= 1'b1;
      scl_s     <= 1'b1;
      scl_d     <= 1'b1;
      sda_meta  <= 1'b1;
      sda_s     <= 1'b1;
      sda_d     <= 1'b1;
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      tcnt_q    <= '0;
      data      <= '0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
    end else begin
      scl_meta  <= scl;
      scl_s     <= scl_meta;
      scl_d     <= scl_s;
      sda_meta  <= sda;
      sda_s     <= sda_meta;
      sda_d     <= sda_s;
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      tcnt_q    <= tcnt_d;
      data      <= data_d;
      valid     <= valid_d;
      busy      <= busy_d;
      err       <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    data_d    = data;
    valid_d   = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      StIdle: begin
        if (start_c) begin
          state_d   = StRecv;
          bit_cnt_d = '0;
        end
      end
      StRecv: begin
        if (start_c) begin
          bit_cnt_d = '0;
        end else if (stop_c) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (scl_rise) begin
          shreg_d   = {shreg_q[DATA_W-2:0], sda_s};
          bit_cnt_d = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == LastBit) state_d = StWaitStop;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StWaitStop: begin
        // The trailing scl high phase (sda low) precedes STOP and is not data.
        if (stop_c) begin
          data_d  = shreg_q;
          valid_d = 1'b1;
          state_d = StIdle;
        end else if (start_c) begin
          err_d     = 1'b1;
          state_d   = StRecv;
          bit_cnt_d = '0;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);

    if (state_d == StIdle || scl_edge || start_c) begin
      tcnt_d = '0;
    end else begin
      tcnt_d = tcnt_q + TW'(1);
    end
  end

endmodule

// File: tb/tb_i2c_nibble_rx.sv
// Directed bench for i2c_nibble_rx: table of clean frames plus hand-written corner sequences.
module tb_i2c_nibble_rx;

  localparam int Q = 4;  // quarter scl period in sclk cycles (80 ns half-period)

  logic       sclk;
  logic       rst;
  logic       scl;
  logic       sda;
  logic [3:0] data;
  logic       valid;
  logic       busy;
  logic       err;

  int vecs = 0;
  int miss = 0;

  int valid_cnt = 0;
  int err_cnt   = 0;
  int both_cnt  = 0;
  int busy_at_valid  = 0;
  int pbusy_at_valid = 0;
  logic prev_busy = 1'b0;

  i2c_nibble_rx #(
    .DATA_W (4),
    .TIMEOUT(16)
  ) dut (
    .sclk (sclk),
    .rst  (rst),
    .scl  (scl),
    .sda  (sda),
    .data (data),
    .valid(valid),
    .busy (busy),
    .err  (err)
  );

  initial begin
    sclk = 1'b0;
    forever #5 sclk = ~sclk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  always @(negedge sclk) begin
    if (valid) begin
      valid_cnt      <= valid_cnt + 1;
      busy_at_valid  <= int'(busy);
      pbusy_at_valid <= int'(prev_busy);
    end
    if (err) err_cnt <= err_cnt + 1;
    if (valid && err) both_cnt <= both_cnt + 1;
    prev_busy <= busy;
  end

  typedef struct {
    logic [3:0] word;
    logic [3:0] exp_data;
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge sclk);
  endtask

  task automatic bus_start();
    sda = 1'b1; scl = 1'b1; cyc(Q);
    sda = 1'b0; cyc(Q);
    scl = 1'b0; cyc(Q);
  endtask

  task automatic send_bit(input logic b);
    sda = b;    cyc(Q);
    scl = 1'b1; cyc(2 * Q);
    scl = 1'b0; cyc(Q);
  endtask

  // A '1' bit whose high phase carries a repeated START.
  task automatic rep_start();
    sda = 1'b1; cyc(Q);
    scl = 1'b1; cyc(Q);
    sda = 1'b0; cyc(Q);
    scl = 1'b0; cyc(Q);
  endtask

  task automatic bus_stop();
    sda = 1'b0; cyc(Q);
    scl = 1'b1; cyc(Q);
    sda = 1'b1; cyc(2 * Q);
  endtask

  task automatic send_frame(input logic [3:0] w);
    bus_start();
    for (int i = 3; i >= 0; i--) send_bit(w[i]);
    bus_stop();
  endtask

  initial begin
    int v0, e0, hit;

    tbl[0] = '{word: 4'h3, exp_data: 4'h3};
    tbl[1] = '{word: 4'hC, exp_data: 4'hC};
    tbl[2] = '{word: 4'h0, exp_data: 4'h0};
    tbl[3] = '{word: 4'hF, exp_data: 4'hF};

    rst = 1'b1; scl = 1'b1; sda = 1'b1;
    cyc(3);
    chk("reset data", int'(data), 0);
    chk("reset valid", int'(valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset err", int'(err), 0);
    rst = 1'b0;
    cyc(4);

    // Test 1: frame 4'hB with latency checks on START and STOP.
    v0 = valid_cnt; e0 = err_cnt;
    sda = 1'b1; scl = 1'b1; cyc(Q);
    sda = 1'b0;
    cyc(2);
    chk("t1 busy before start+3", int'(busy), 0);
    cyc(1);
    chk("t1 busy at start+3", int'(busy), 1);
    cyc(Q - 3);
    scl = 1'b0; cyc(Q);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    sda = 1'b0; cyc(Q);
    scl = 1'b1; cyc(Q);
    sda = 1'b1;
    cyc(2);
    chk("t1 valid before stop+3", int'(valid), 0);
    cyc(1);
    chk("t1 valid at stop+3", int'(valid), 1);
    chk("t1 data", int'(data), 4'hB);
    chk("t1 busy at valid", int'(busy), 0);
    cyc(2 * Q);
    chk("t1 valid count", valid_cnt - v0, 1);
    chk("t1 err count", err_cnt - e0, 0);
    chk("t1 busy before valid", pbusy_at_valid, 1);

    // Test 2 and more: clean back-to-back frames from the table.
    for (int i = 0; i < 4; i++) begin
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(tbl[i].word);
      chk($sformatf("tbl%0d valid count", i), valid_cnt - v0, 1);
      chk($sformatf("tbl%0d err count", i), err_cnt - e0, 0);
      chk($sformatf("tbl%0d data", i), int'(data), int'(tbl[i].exp_data));
      chk($sformatf("tbl%0d busy between", i), int'(busy), 0);
      chk($sformatf("tbl%0d busy at valid", i), busy_at_valid, 0);
    end

    // Test 3: short frame aborted by STOP.
    v0 = valid_cnt; e0 = err_cnt;
    bus_start(); send_bit(1'b1); send_bit(1'b0); bus_stop();
    chk("t3 err count", err_cnt - e0, 1);
    chk("t3 valid count", valid_cnt - v0, 0);
    chk("t3 data kept", int'(data), 4'hF);
    chk("t3 busy", int'(busy), 0);

    // Test 4: repeated START after three bits restarts the frame without error.
    v0 = valid_cnt; e0 = err_cnt;
    bus_start(); send_bit(1'b1); send_bit(1'b1); rep_start();
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    bus_stop();
    chk("t4 valid count", valid_cnt - v0, 1);
    chk("t4 err count", err_cnt - e0, 0);
    chk("t4 data", int'(data), 4'h5);

    // Test 5: scl stuck high mid-frame triggers timeout.
    v0 = valid_cnt; e0 = err_cnt;
    bus_start(); send_bit(1'b1);
    sda = 1'b0; cyc(Q);
    scl = 1'b1;
    hit = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge sclk);
      if (err && hit == 0) hit = i;
    end
    chk("t5 timeout cycle", hit, 19);
    chk("t5 err count", err_cnt - e0, 1);
    chk("t5 valid count", valid_cnt - v0, 0);
    chk("t5 busy", int'(busy), 0);
    sda = 1'b1; cyc(2 * Q);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(4'hA);
    chk("t5 next valid count", valid_cnt - v0, 1);
    chk("t5 next err count", err_cnt - e0, 0);
    chk("t5 next data", int'(data), 4'hA);

    // Test 6: reset during bit 2 kills the frame silently.
    v0 = valid_cnt; e0 = err_cnt;
    bus_start(); send_bit(1'b0);
    sda = 1'b1; cyc(Q);
    scl = 1'b1; cyc(Q);
    rst = 1'b1;
    cyc(1);
    chk("t6 rst data", int'(data), 0);
    chk("t6 rst valid", int'(valid), 0);
    chk("t6 rst busy", int'(busy), 0);
    chk("t6 rst err", int'(err), 0);
    rst = 1'b0;
    cyc(Q - 1);
    scl = 1'b0; cyc(Q);
    send_bit(1'b1); send_bit(1'b0); bus_stop();
    chk("t6 broken valid count", valid_cnt - v0, 0);
    chk("t6 broken err count", err_cnt - e0, 0);
    send_frame(4'h6);
    chk("t6 next valid count", valid_cnt - v0, 1);
    chk("t6 next data", int'(data), 4'h6);

    chk("valid and err together", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule
